// File: rtl/dds_phase_core_if.sv
// ROM lookup bus between the DDS phase core (master) and the quarter-wave sine ROM (slave).
interface dds_phase_core_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-3:0] rom_addr;
  logic [DATA_W-2:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/dds_phase_core.sv
// DDS phase accumulator: debounced/clamped step capture, wrap-aligned step swap, quarter-wave ROM fold
// and offset-binary reconstruction. Optional lookup dither enabled by defining DDS_DITHER_EN.
module dds_phase_core #(
  parameter int ACC_W         = 32,
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 8,
  parameter int STEP_MIN      = 10000,
  parameter int STEP_MAX      = 2000000,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Step,
  input  logic                enable,
  dds_phase_core_if.master    rom_if,
  output logic [DATA_W-1:0]   dac_data,
  output logic                square,
  output logic                sync,
  output logic [31:0]         active_step
);

  localparam int                 CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_ACC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_STOP = CNT_W'(STABLE_CYCLES);
  localparam logic [31:0]        SMIN     = 32'(STEP_MIN);
  localparam logic [31:0]        SMAX     = 32'(STEP_MAX);

  function automatic logic [31:0] clamp_step(input logic [31:0] s);
    if (s < SMIN)      return SMIN;
    else if (s > SMAX) return SMAX;
    else               return s;
  endfunction

  logic [31:0]       r_s1, r_s2, r_pending;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pflag;
  logic [ACC_W-1:0]  r_acc;
  logic              r_wrap;

  logic [ACC_W:0]    w_sum;
  logic              w_carry, w_accept, w_swap;
  logic [ACC_W-1:0]  w_phase;

  assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(active_step);
  assign w_carry  = enable & w_sum[ACC_W];
  assign w_accept = (r_cnt == CNT_ACC);
  assign w_swap   = r_pflag & (w_carry | ~enable);

`ifdef DDS_DITHER_EN
  localparam int DITH_W = ((ACC_W - ADDR_W) < 16) ? (ACC_W - ADDR_W) : 16;
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_lfsr <= 16'hACE1;
    else if (enable) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Dither perturbs only the lookup phase; stored phase, square and sync stay exact.
  assign w_phase = r_acc + ACC_W'(r_lfsr[DITH_W-1:0]);
`else
  assign w_phase = r_acc;
`endif

  // Step capture, debounce, acceptance and swap; a fresh acceptance keeps the flag set over a swap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_cnt       <= '0;
      r_pending   <= SMIN;
      r_pflag     <= 1'b0;
      active_step <= SMIN;
      r_acc       <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_s1 <= Step;
      r_s2 <= r_s1;
      if (r_s1 != r_s2)       r_cnt <= '0;
      else if (w_accept)      r_cnt <= CNT_STOP;
      else if (r_cnt != CNT_STOP) r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_pending <= clamp_step(r_s2);
        r_pflag   <= 1'b1;
      end else if (w_swap) begin
        r_pflag   <= 1'b0;
      end
      if (w_swap) active_step <= r_pending;

      if (enable) r_acc <= w_sum[ACC_W-1:0];
      r_wrap <= w_carry;
    end
  end

  logic [ADDR_W-1:0] w_p;
  logic [1:0]        w_q;
  logic [ADDR_W-3:0] w_idx;
  logic              r_sign_p1, r_msb_p1, r_wrap_p1;
  logic              r_sign_p2, r_msb_p2, r_wrap_p2;

  assign w_p   = w_phase[ACC_W-1 -: ADDR_W];
  assign w_q   = w_p[ADDR_W-1:ADDR_W-2];
  assign w_idx = w_p[ADDR_W-3:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_if.rom_addr <= '0;
      r_sign_p1       <= 1'b0;
      r_msb_p1        <= 1'b0;
      r_wrap_p1       <= 1'b0;
      r_sign_p2       <= 1'b0;
      r_msb_p2        <= 1'b0;
      r_wrap_p2       <= 1'b0;
      dac_data        <= DATA_W'(1) << (DATA_W - 1);
      square          <= 1'b0;
      sync            <= 1'b0;
    end else begin
      // Stage 1: quadrant fold into the quarter-wave address
      rom_if.rom_addr <= w_q[0] ? ~w_idx : w_idx;
      r_sign_p1       <= w_q[1];
      r_msb_p1        <= r_acc[ACC_W-1];
      r_wrap_p1       <= r_wrap;
      // Stage 2: ROM read latency
      r_sign_p2       <= r_sign_p1;
      r_msb_p2        <= r_msb_p1;
      r_wrap_p2       <= r_wrap_p1;
      // Stage 3: offset-binary reconstruction
      dac_data        <= r_sign_p2 ? {1'b0, ~rom_if.rom_data} : {1'b1, rom_if.rom_data};
      square          <= r_msb_p2;
      sync            <= r_wrap_p2;
    end
  end

endmodule

// File: tb/tb_dds_phase_core.sv
// Directed bench for dds_phase_core: behavioural phase/step model compared every cycle plus literal checks.
module tb_dds_phase_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Step = 32'd0;
  logic        enable = 1'b0;
  logic [7:0]  dac_data;
  logic        square, sync;
  logic [31:0] active_step;

  int checks = 0;
  int errors = 0;
  bit rom_mode = 1'b0;
  bit chk_en = 1'b1;

  dds_phase_core_if #(.ADDR_W(10), .DATA_W(8)) rif ();

  dds_phase_core dut (
    .clk(clk), .reset(reset), .Step(Step), .enable(enable), .rom_if(rif),
    .dac_data(dac_data), .square(square), .sync(sync), .active_step(active_step)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] rom_fn(input logic [7:0] a);
    if (rom_mode) return 7'h7F;
    return a[7:1];
  endfunction

  function automatic int addr_of(input logic [31:0] acc);
    int p, q, idx;
    p = int'(acc >> 22);
    q = p / 256;
    idx = p % 256;
    return (q % 2 == 1) ? 255 - idx : idx;
  endfunction

  function automatic int dac_of(input logic [31:0] acc);
    int q, mag;
    q = int'(acc >> 30);
    mag = int'(rom_fn(8'(addr_of(acc))));
    return (q >= 2) ? 127 - mag : 128 + mag;
  endfunction

  function automatic logic [31:0] clampf(input logic [31:0] s);
    if (s < 32'd10000) return 32'd10000;
    if (s > 32'd2000000) return 32'd2000000;
    return s;
  endfunction

  // ROM slave: data valid one cycle after the address.
  always @(posedge clk or negedge reset) begin
    if (!reset) rif.rom_data <= rom_fn(8'd0);
    else        rif.rom_data <= rom_fn(rif.rom_addr);
  end

  // Behavioural model state
  logic [31:0] m_acc_h [0:3];
  bit          m_wrp_h [0:3];
  logic [31:0] m_hist  [0:6];
  logic [31:0] m_pend, m_active;
  bit          m_flag;
  int          m_k;

  always @(posedge clk or negedge reset) begin
    logic [32:0] sum;
    bit carry, accept;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin m_acc_h[i] = 0; m_wrp_h[i] = 0; end
      for (int i = 0; i < 7; i++) m_hist[i] = 0;
      m_pend = 32'd10000; m_active = 32'd10000; m_flag = 0; m_k = 0;
    end else begin
      for (int i = 6; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = Step;
      if (m_k < 1000) m_k++;
      // A value is accepted once it has sat in the second capture stage for STABLE_CYCLES samples.
      accept = (m_k >= 4) && (m_hist[2] == m_hist[3]) && (m_hist[3] == m_hist[4]) &&
               (m_hist[4] == m_hist[5]) && ((m_k == 4) || (m_hist[5] != m_hist[6]));
      sum = {1'b0, m_acc_h[0]} + {1'b0, m_active};
      carry = enable && sum[32];
      if (m_flag && (carry || !enable)) begin
        m_active = m_pend;
        m_flag = 0;
      end
      if (accept) begin
        m_pend = clampf(m_hist[2]);
        m_flag = 1;
      end
      for (int i = 3; i > 0; i--) begin m_acc_h[i] = m_acc_h[i-1]; m_wrp_h[i] = m_wrp_h[i-1]; end
      if (enable) m_acc_h[0] = sum[31:0];
      m_wrp_h[0] = carry;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rom_addr", 64'(rif.rom_addr), 64'(addr_of(m_acc_h[1])));
      chk("dac_data", 64'(dac_data), 64'(dac_of(m_acc_h[3])));
      chk("square", 64'(square), 64'(m_acc_h[3][31]));
      chk("sync", 64'(sync), 64'(m_wrp_h[3]));
      chk("active_step", 64'(active_step), 64'(m_active));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sync(output int n, output bit ok);
    n = 0; ok = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      n++;
      if (sync) begin ok = 1; break; end
    end
  endtask

  initial begin
    int n;
    bit ok;
    #2 reset = 1'b0;
    #1;
    chk("reset_dac", 64'(dac_data), 64'h80);
    chk("reset_active", 64'(active_step), 64'd10000);
    chk("reset_sync", 64'(sync), 64'd0);
    chk("reset_addr", 64'(rif.rom_addr), 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc(10);

    // Clamp with enable low: swap is immediate.
    Step = 32'd5;
    cyc(12);
    chk("clamp_low", 64'(active_step), 64'd10000);
    Step = 32'd3000000;
    cyc(12);
    chk("clamp_high", 64'(active_step), 64'd2000000);

    // Glitching input never becomes pending.
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      Step = (i % 2 == 0) ? 32'd20000 : 32'd30000;
      cyc(2);
    end
    chk("glitch_active", 64'(active_step), 64'd2000000);

    // Acceptance takes effect at a wrap, then steady period.
    Step = 32'd1048576;
    cyc(10);
    wait_sync(n, ok);
    chk("sync_seen_1", 64'(ok), 64'd1);
    wait_sync(n, ok);
    chk("sync_seen_2", 64'(ok), 64'd1);
    wait_sync(n, ok);
    chk("sync_seen_3", 64'(ok), 64'd1);
    chk("sync_period", 64'(n), 64'd4096);
    chk("wrap_active", 64'(active_step), 64'd1048576);
    cyc(777);

    // Freeze and resume.
    enable = 1'b0;
    cyc(50);
    enable = 1'b1;
    cyc(300);

    // Constant-magnitude ROM: rails selected purely by the sign quadrant.
    chk_en = 1'b0;
    rom_mode = 1'b1;
    cyc(4);
    chk_en = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      cyc(1);
      chk("recon_rail", 64'(dac_data), square ? 64'h00 : 64'hFF);
    end
    chk_en = 1'b0;
    rom_mode = 1'b0;
    cyc(4);
    chk_en = 1'b1;
    cyc(123);

    // Asynchronous reset mid-run.
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midreset_dac", 64'(dac_data), 64'h80);
    chk("midreset_active", 64'(active_step), 64'd10000);
    chk("midreset_sync", 64'(sync), 64'd0);
    chk("midreset_square", 64'(square), 64'd0);
    chk("midreset_addr", 64'(rif.rom_addr), 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_phase_core.md
# dds_phase_core

Phase-accumulator core of the DDS signal path: consumes the 32-bit frequency word `Step` produced by the front-panel step generator and turns it into a phase-continuous waveform. `Step` is combinational and button-driven, so the core debounces and clamps it, then swaps it in only at a phase wrap. The accumulator phase is folded into a quarter-wave sine ROM address. The ROM magnitude is reconstructed into an offset-binary DAC sample, with a square output and a wrap pulse alongside.

## Interface
Parameters:
- `ACC_W`, 32, accumulator width
- `ADDR_W`, 10, full-wave phase bits used for lookup (ROM holds 2^(ADDR_W-2) entries)
- `DATA_W`, 8, DAC sample width
- `STEP_MIN`, 10000, lower clamp on accepted step
- `STEP_MAX`, 2000000, upper clamp on accepted step
- `STABLE_CYCLES`, 4, cycles `Step` must hold before acceptance

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Step`  in  32  requested phase increment, asynchronous to edits, may glitch
- `enable`  in  1  1 = accumulate, 0 = freeze
- `rom_addr`  out  ADDR_W-2  quarter-wave ROM address (registered)
- `rom_data`  in  DATA_W-1  ROM magnitude, valid exactly 1 cycle after `rom_addr`
- `dac_data`  out  DATA_W  offset-binary sample
- `square`  out  1  accumulator MSB, latency-aligned with `dac_data`
- `sync`  out  1  one-cycle pulse on accumulator wrap, latency-aligned with `dac_data`
- `active_step`  out  32  increment currently in use

## Operation
- **Input capture:** `Step` is registered twice (s1, s2). A stability counter increments while s2 equals its previous value and resets to 0 on any change.
- **Acceptance:** when the counter reaches STABLE_CYCLES-1, set `pending = clamp(s2)` and `pending_flag = 1`. Clamp: below STEP_MIN gives STEP_MIN; above STEP_MAX gives STEP_MAX; unsigned compare. A held value re-arms nothing, so acceptance fires once per distinct stable value.
- **Swap:** `active_step <= pending` and `pending_flag` clears when either condition holds:
  - a carry-out occurs this cycle; the new step applies from the next add, so phase stays continuous;
  - `enable` = 0, so the swap is immediate.
- **Swap vs new acceptance:** if acceptance and swap coincide, the newly accepted value wins and `pending_flag` stays set.
- **Accumulator:** when `enable` = 1, `acc <= acc + active_step` mod 2^ACC_W, and the carry-out sets the wrap flag. When `enable` = 0, `acc` holds and no wrap is generated.
- **Pipeline** (advances every cycle, including while disabled):
  - Stage 1: `p` = top ADDR_W bits of the lookup phase, quadrant `q = p[ADDR_W-1:ADDR_W-2]`, `idx = p[ADDR_W-3:0]`. `rom_addr <= q[0] ? ~idx : idx`. Sign `q[1]`, MSB and wrap are delayed in step.
  - Stage 2: ROM latency; sideband signals are delayed again.
  - Stage 3: `dac_data <= sign ? {1'b0, ~rom_data} : {1'b1, rom_data}`. `square` and `sync` are registered alongside.

## Timing
- **Reset values:** `acc` 0, `active_step` = `pending` = STEP_MIN, `pending_flag` 0, stability counter 0, s1/s2 0, `rom_addr` 0, `dac_data` = 2^(DATA_W-1) (0x80), `square` 0, `sync` 0.
- **Reset mid-operation:** all state returns to the reset values immediately and asynchronously; the pipeline is flushed with no stale `sync`.
- **Step latency:** a change on `Step` reaches `pending` after 2 + STABLE_CYCLES cycles minimum, and `active_step` at the next wrap (or immediately if disabled).
- **Output latency:** `acc` value at cycle n gives `rom_addr` at n+1 and `dac_data`/`square`/`sync` at n+3.
- **`sync` width:** exactly 1 cycle per wrap, even at STEP_MAX.

## Configuration
- `DDS_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1) advances on each enabled cycle.
  - Its low min(16, ACC_W-ADDR_W) bits are added to `acc` to form the lookup phase only; stored `acc`, `square` and `sync` are unaffected.
- Undefined: lookup phase = `acc`, no LFSR logic.

## Test plan
- **Reset:** assert `reset` = 0 mid-run with `acc` nonzero -> all outputs at reset values the same cycle; `dac_data` = 0x80, `active_step` = 10000.
- **Acceptance at wrap:** `Step` = 1048576 held, `enable` = 1 -> `pending` updates 6 cycles later, `active_step` changes only on the cycle after the next carry. Thereafter `sync` period = 4096 cycles and `rom_addr` runs 0..255 then 255..0, each value held 4 cycles.
- **Glitch rejection:** `Step` toggles between 20000 and 30000 every 2 cycles for 100 cycles -> `pending_flag` never sets and `active_step` is unchanged.
- **Clamp:** stable `Step` = 5 with `enable` = 0 -> `active_step` = 10000; stable `Step` = 3000000 -> `active_step` = 2000000.
- **Freeze:** drop `enable` for 50 cycles -> `acc` constant, `sync` 0, `dac_data` constant after 3 cycles; re-enable -> accumulation resumes from the held phase.
- **Reconstruction:** ROM model returns `rom_data` = 0x7F for every address -> `dac_data` = 0xFF in quadrants 0–1 and 0x00 in quadrants 2–3, 3-cycle latency from the `acc` transition.
